// File: rtl/rv32i_types.sv
// Types shared by the rv32i datapath blocks. This file holds the data-memory
// arbiter state encoding and the full-word byte mask.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE
  } dmem_arb_state_t;

  localparam logic [3:0] WORD_BYTE_EN = 4'hF;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-cache port between speculative loads and committed
// stores. Stores win unless a waiting load has lost STORE_STREAK_MAX times in a row.
module dmem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STORE_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_byte_en,
  output logic        st_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned STREAK_W = (STORE_STREAK_MAX < 1) ? 1 : $clog2(STORE_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STORE_STREAK_MAX);

  dmem_arb_state_t     state_q, state_d;
  logic                squash_q, squash_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [31:0]         mem_address_q, mem_address_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;

  logic ld_eligible;
  logic streak_at_max;

  assign ld_eligible   = ld_req & ~flush;
  assign streak_at_max = (streak_q == STREAK_MAX);

  // NOTE: every next-state variable gets its hold value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    squash_d      = squash_q;
    streak_d      = streak_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;

    unique case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if (st_req && !(ld_eligible && streak_at_max)) begin
          state_d       = STORE;
          mem_write_d   = 1'b1;
          mem_address_d = st_addr;
          mem_wdata_d   = st_wdata;
          mem_be_d      = st_byte_en;
          if (!ld_eligible) begin
            streak_d = '0;
          end else if (!streak_at_max) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (ld_eligible) begin
          state_d       = LOAD;
          mem_read_d    = 1'b1;
          mem_address_d = ld_addr;
          mem_wdata_d   = '0;
          mem_be_d      = WORD_BYTE_EN;
          streak_d      = '0;
        end
      end

      LOAD: begin
        // The cache cannot abort a read, so a flush only marks the data as dead.
        if (flush) begin
          squash_d = 1'b1;
        end
        if (mem_resp) begin
          state_d       = IDLE;
          squash_d      = 1'b0;
          mem_read_d    = 1'b0;
          mem_address_d = '0;
          mem_be_d      = '0;
        end
      end

      STORE: begin
        if (mem_resp) begin
          state_d       = IDLE;
          mem_write_d   = 1'b0;
          mem_address_d = '0;
          mem_wdata_d   = '0;
          mem_be_d      = '0;
        end
      end

      default: begin
        state_d       = IDLE;
        squash_d      = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = '0;
        mem_wdata_d   = '0;
        mem_be_d      = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      squash_q      <= 1'b0;
      streak_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
    end else begin
      state_q       <= state_d;
      squash_q      <= squash_d;
      streak_q      <= streak_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;

  assign ld_resp  = (state_q == LOAD) & mem_resp & ~squash_q & ~flush;
  assign ld_rdata = ld_resp ? mem_rdata : '0;
  assign st_resp  = (state_q == STORE) & mem_resp;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a latency-programmable cache model checks each grant
// against a queue of expected grants, and a response queue checks ld/st pulses.
module tb_dmem_arbiter;

  typedef struct {
    logic        is_st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } grant_t;

  typedef struct {
    logic        is_st;
    logic [31:0] data;
  } resp_t;

  localparam logic [31:0] GARBAGE = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_byte_en;
  logic        st_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        busy;

  dmem_arbiter #(.STORE_STREAK_MAX(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .ld_req          (ld_req),
    .ld_addr         (ld_addr),
    .ld_resp         (ld_resp),
    .ld_rdata        (ld_rdata),
    .st_req          (st_req),
    .st_addr         (st_addr),
    .st_wdata        (st_wdata),
    .st_byte_en      (st_byte_en),
    .st_resp         (st_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  grant_t      grant_q[$];
  resp_t       resp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 3;
  int          cnt      = 0;
  int          resp_cyc = 0;
  logic        in_xfer  = 1'b0;
  logic        prev_resp_valid = 1'b0;
  logic        chk_gap  = 1'b0;
  logic        st_hold  = 1'b0;
  logic [31:0] cur_rdata = '0;
  logic [31:0] hold_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_load(input logic [31:0] addr, input logic [31:0] rdata, input logic with_resp);
    grant_t g;
    resp_t  r;
    g.is_st = 1'b0; g.addr = addr; g.wdata = '0; g.be = 4'hF; g.rdata = rdata;
    grant_q.push_back(g);
    if (with_resp) begin
      r.is_st = 1'b0; r.data = rdata;
      resp_q.push_back(r);
    end
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic with_resp);
    grant_t g;
    resp_t  r;
    g.is_st = 1'b1; g.addr = addr; g.wdata = wdata; g.be = be; g.rdata = GARBAGE;
    grant_q.push_back(g);
    if (with_resp) begin
      r.is_st = 1'b1; r.data = '0;
      resp_q.push_back(r);
    end
  endtask

  // One clock: cache model acts at the falling edge, responses are sampled 1ns later.
  task automatic cycle();
    grant_t g;
    resp_t  r;
    @(negedge clk);
    cyc++;
    if (mem_resp) begin
      mem_resp  = 1'b0;
      mem_rdata = GARBAGE;
      in_xfer   = 1'b0;
    end else if (mem_read || mem_write) begin
      if (!in_xfer) begin
        in_xfer   = 1'b1;
        cnt       = 0;
        hold_addr = mem_address;
        if (chk_gap && prev_resp_valid) check("turnaround", cyc - resp_cyc, 2);
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 1, 0);
          cur_rdata = GARBAGE;
        end else begin
          g = grant_q.pop_front();
          check("grant_kind", {31'b0, mem_write}, {31'b0, g.is_st});
          check("grant_addr", mem_address, g.addr);
          check("grant_be", {28'b0, mem_byte_enable}, {28'b0, g.be});
          if (g.is_st) check("grant_wdata", mem_wdata, g.wdata);
          cur_rdata = g.rdata;
        end
      end else begin
        cnt++;
        check("addr_hold", mem_address, hold_addr);
      end
      if (cnt == lat) begin
        mem_resp        = 1'b1;
        mem_rdata       = cur_rdata;
        resp_cyc        = cyc;
        prev_resp_valid = 1'b1;
      end
    end
    #1;
    check("rw_exclusive", {31'b0, mem_read & mem_write}, 0);
    if (!ld_resp) check("ld_rdata_zero", ld_rdata, 0);
    if (ld_resp || st_resp) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", {30'b0, st_resp, ld_resp}, 0);
      end else begin
        r = resp_q.pop_front();
        check("resp_kind", {30'b0, st_resp, ld_resp}, r.is_st ? 32'd2 : 32'd1);
        if (ld_resp) check("ld_rdata", ld_rdata, r.data);
      end
    end
    if (ld_resp) ld_req = 1'b0;
    if (st_resp && !st_hold) st_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      cycle();
      done = (grant_q.size() == 0) && (resp_q.size() == 0) && !busy;
    end
    if (!done) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    ld_req = 1'b0; ld_addr = '0;
    st_req = 1'b0; st_addr = '0; st_wdata = '0; st_byte_en = '0;
    mem_resp = 1'b0; mem_rdata = GARBAGE;

    // Reset state
    #12;
    check("rst_mem_read", {31'b0, mem_read}, 0);
    check("rst_mem_write", {31'b0, mem_write}, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_resps", {30'b0, st_resp, ld_resp}, 0);
    cycle();
    rst = 1'b1;
    cycle();

    // 1: single load, 3-cycle cache latency
    lat = 3;
    push_load(32'h100, 32'hDEAD_BEEF, 1'b1);
    ld_req = 1'b1; ld_addr = 32'h100;
    cycle();
    check("t1_mem_read", {31'b0, mem_read}, 1);
    check("t1_busy", {31'b0, busy}, 1);
    for (int n = 0; n < 50 && resp_q.size() != 0; n++) cycle();
    check("t1_resp_seen", resp_q.size(), 0);
    cycle();
    check("t1_busy_after", {31'b0, busy}, 0);
    check("t1_read_after", {31'b0, mem_read}, 0);

    // 2: simultaneous load and store, store first then load after one IDLE cycle
    lat = 2; chk_gap = 1'b1; prev_resp_valid = 1'b0;
    push_store(32'h300, 32'h1234_5678, 4'b0011, 1'b1);
    push_load(32'h200, 32'h0200_0200, 1'b1);
    ld_req = 1'b1; ld_addr = 32'h200;
    st_req = 1'b1; st_addr = 32'h300; st_wdata = 32'h1234_5678; st_byte_en = 4'b0011;
    wait_idle("t2");

    // 3: starvation guard, grants S,S,S,S,L,S
    lat = 1; prev_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) push_store(32'h400, 32'hCAFE_0001, 4'hF, 1'b1);
    push_load(32'h500, 32'h0BAD_F00D, 1'b1);
    push_store(32'h400, 32'hCAFE_0001, 4'hF, 1'b1);
    st_hold = 1'b1;
    st_req = 1'b1; st_addr = 32'h400; st_wdata = 32'hCAFE_0001; st_byte_en = 4'hF;
    ld_req = 1'b1; ld_addr = 32'h500;
    for (int n = 0; n < 200 && grant_q.size() != 0; n++) cycle();
    check("t3_grants_done", grant_q.size(), 0);
    st_hold = 1'b0;
    wait_idle("t3");
    chk_gap = 1'b0;

    // 4: one-cycle flush two cycles into a load; response is swallowed
    lat = 6;
    push_load(32'h600, 32'h1212_1212, 1'b0);
    ld_req = 1'b1; ld_addr = 32'h600;
    cycle(); cycle(); cycle();
    flush = 1'b1; ld_req = 1'b0;
    cycle();
    flush = 1'b0;
    check("t4_read_held", {31'b0, mem_read}, 1);
    cycle();
    check("t4_read_held2", {31'b0, mem_read}, 1);
    wait_idle("t4_load");
    lat = 1;
    push_store(32'h640, 32'h6464_6464, 4'b1111, 1'b1);
    st_req = 1'b1; st_addr = 32'h640; st_wdata = 32'h6464_6464; st_byte_en = 4'hF;
    wait_idle("t4_store");

    // 5: flush in IDLE makes the load ineligible
    lat = 2;
    flush = 1'b1;
    push_store(32'h700, 32'h7777_0000, 4'b0100, 1'b1);
    ld_req = 1'b1; ld_addr = 32'h780;
    st_req = 1'b1; st_addr = 32'h700; st_wdata = 32'h7777_0000; st_byte_en = 4'b0100;
    wait_idle("t5_store");
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_no_ld_grant", {31'b0, mem_read}, 0);
    end
    ld_req = 1'b0; flush = 1'b0;
    cycle();

    // mem_resp while IDLE is ignored
    mem_resp = 1'b1; mem_rdata = 32'h0000_BEEF;
    #1;
    check("idle_resp_ignored", {30'b0, st_resp, ld_resp}, 0);
    cycle();
    cycle();
    check("idle_resp_busy", {31'b0, busy}, 0);

    // 6: asynchronous reset in the middle of a store
    lat = 8;
    push_store(32'h800, 32'h55AA_55AA, 4'b1100, 1'b0);
    st_req = 1'b1; st_addr = 32'h800; st_wdata = 32'h55AA_55AA; st_byte_en = 4'b1100;
    cycle(); cycle();
    check("t6_write_before", {31'b0, mem_write}, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_mem_write", {31'b0, mem_write}, 0);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_mem_address", mem_address, 0);
    check("t6_mem_wdata", mem_wdata, 0);
    check("t6_mem_be", {28'b0, mem_byte_enable}, 0);
    check("t6_st_resp", {31'b0, st_resp}, 0);
    st_req = 1'b0; mem_resp = 1'b0; mem_rdata = GARBAGE; in_xfer = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t6_no_st_resp", {31'b0, st_resp}, 0);
    end
    check("t6_idle_after", {31'b0, busy}, 0);

    // A load after the squash and the reset completes normally
    lat = 0;
    push_load(32'h900, 32'h9999_0001, 1'b1);
    ld_req = 1'b1; ld_addr = 32'h900;
    wait_idle("t7");

    check("grant_q_drained", grant_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
